// File: rtl/memory_access_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | memory_access_arbiter                                                    |
// | Shares one variable-latency memory port between fetch and data stages.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module memory_access_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetchReq,
  input  logic [ADDR_WIDTH-1:0] fetchAddress,
  output logic [DATA_WIDTH-1:0] fetchInstruction,
  output logic                  fetchValid,
  output logic                  fetchStall,
  input  logic                  dataRead,
  input  logic                  dataWrite,
  input  logic [ADDR_WIDTH-1:0] dataAddress,
  input  logic [DATA_WIDTH-1:0] dataWriteData,
  output logic [DATA_WIDTH-1:0] dataReadData,
  output logic                  dataValid,
  output logic                  dataStall,
  output logic                  memEnable,
  output logic                  memWriteEnable,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memWriteData,
  input  logic [DATA_WIDTH-1:0] memReadData,
  input  logic                  memReady
);

  localparam int                c_CW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CW-1:0]   c_LIMIT = c_CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } state_t;

  state_t                r_state, w_stateNext;
  logic [c_CW-1:0]       r_starveCount, w_starveNext;
  logic                  r_memEnable, w_memEnableNext;
  logic                  r_memWriteEnable, w_memWriteEnableNext;
  logic [ADDR_WIDTH-1:0] r_memAddress, w_memAddressNext;
  logic [DATA_WIDTH-1:0] r_memWriteData, w_memWriteDataNext;

  logic w_dataReq;
  logic w_forceFetch;

  assign w_dataReq    = dataRead | dataWrite;
  assign w_forceFetch = fetchReq & (r_starveCount == c_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= IDLE;
      r_starveCount    <= '0;
      r_memEnable      <= 1'b0;
      r_memWriteEnable <= 1'b0;
      r_memAddress     <= '0;
      r_memWriteData   <= '0;
    end else begin
      r_state          <= w_stateNext;
      r_starveCount    <= w_starveNext;
      r_memEnable      <= w_memEnableNext;
      r_memWriteEnable <= w_memWriteEnableNext;
      r_memAddress     <= w_memAddressNext;
      r_memWriteData   <= w_memWriteDataNext;
    end
  end

  always_comb begin
    w_stateNext          = r_state;
    w_starveNext         = r_starveCount;
    w_memEnableNext      = r_memEnable;
    w_memWriteEnableNext = r_memWriteEnable;
    w_memAddressNext     = r_memAddress;
    w_memWriteDataNext   = r_memWriteData;
    case (r_state)
      IDLE: begin
        if (w_dataReq && !w_forceFetch) begin
          w_stateNext          = DATA;
          w_memEnableNext      = 1'b1;
          w_memWriteEnableNext = dataWrite;
          w_memAddressNext     = dataAddress;
          w_memWriteDataNext   = dataWriteData;
          // Only grants that make a waiting fetch wait longer count toward starvation
          if (!fetchReq)
            w_starveNext = '0;
          else if (r_starveCount != c_LIMIT)
            w_starveNext = r_starveCount + c_CW'(1);
        end else if (fetchReq) begin
          w_stateNext          = FETCH;
          w_memEnableNext      = 1'b1;
          w_memWriteEnableNext = 1'b0;
          w_memAddressNext     = fetchAddress;
          w_starveNext         = '0;
        end else begin
          w_starveNext = '0;
        end
      end
      DATA, FETCH: begin
        if (memReady) begin
          w_stateNext          = IDLE;
          w_memEnableNext      = 1'b0;
          w_memWriteEnableNext = 1'b0;
        end
      end
      default: begin
        w_stateNext          = IDLE;
        w_memEnableNext      = 1'b0;
        w_memWriteEnableNext = 1'b0;
      end
    endcase
  end

  assign dataValid        = (r_state == DATA) & memReady;
  assign fetchValid       = (r_state == FETCH) & memReady;
  assign dataReadData     = memReadData;
  assign fetchInstruction = memReadData;
  assign dataStall        = w_dataReq & ~dataValid;
  assign fetchStall       = fetchReq & ~fetchValid;

  assign memEnable      = r_memEnable;
  assign memWriteEnable = r_memWriteEnable;
  assign memAddress     = r_memAddress;
  assign memWriteData   = r_memWriteData;

endmodule
`default_nettype wire

// File: tb/tb_memory_access_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_memory_access_arbiter                                                 |
// | Scoreboard bench with a variable-latency memory model.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_memory_access_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetchReq = 1'b0;
  logic [31:0] fetchAddress = '0;
  logic [31:0] fetchInstruction;
  logic        fetchValid, fetchStall;
  logic        dataRead = 1'b0, dataWrite = 1'b0;
  logic [31:0] dataAddress = '0, dataWriteData = '0;
  logic [31:0] dataReadData;
  logic        dataValid, dataStall;
  logic        memEnable, memWriteEnable;
  logic [31:0] memAddress, memWriteData;
  logic [31:0] memReadData = '0;
  logic        memReady = 1'b0;

  memory_access_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .fetchReq(fetchReq), .fetchAddress(fetchAddress), .fetchInstruction(fetchInstruction),
    .fetchValid(fetchValid), .fetchStall(fetchStall),
    .dataRead(dataRead), .dataWrite(dataWrite), .dataAddress(dataAddress),
    .dataWriteData(dataWriteData), .dataReadData(dataReadData),
    .dataValid(dataValid), .dataStall(dataStall),
    .memEnable(memEnable), .memWriteEnable(memWriteEnable), .memAddress(memAddress),
    .memWriteData(memWriteData), .memReadData(memReadData), .memReady(memReady)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        expD[$];
  exp_t        expF[$];
  logic [31:0] memArr[logic [31:0]];
  logic [31:0] sbMem[logic [31:0]];
  byte         gLog[$];
  int          nVec = 0;
  int          nErr = 0;
  int          lat = 0;
  bit          tieReady = 1'b0;
  int          memCnt = 0;

  function automatic logic [31:0] initWord(logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] sbRead(logic [31:0] a);
    return sbMem.exists(a) ? sbMem[a] : initWord(a);
  endfunction

  function automatic logic [31:0] memRead(logic [31:0] a);
    return memArr.exists(a) ? memArr[a] : initWord(a);
  endfunction

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Memory model: ready after lat wait cycles, responses change on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (memEnable) begin
        memReady    = (memCnt == lat);
        memReadData = memReady ? memRead(memAddress) : 32'h0BAD0BAD;
        if (memReady && memWriteEnable) memArr[memAddress] = memWriteData;
        memCnt++;
      end else begin
        memCnt      = 0;
        memReady    = tieReady;
        memReadData = 32'h0;
      end
    end
  end

  // Monitor: scoreboard pops, stall relations and grant order log
  initial begin
    exp_t e;
    bit   prevEn = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      chk("dataStall", 32'(dataStall), 32'((dataRead | dataWrite) & ~dataValid));
      chk("fetchStall", 32'(fetchStall), 32'(fetchReq & ~fetchValid));
      if (memEnable && !prevEn) gLog.push_back(memAddress[13:12] == 2'd1 ? 8'h46 : 8'h44);
      prevEn = memEnable;
      if (dataValid) begin
        if (expD.size() == 0) chk("dataSpurious", 32'd1, 32'd0);
        else begin
          e = expD.pop_front();
          chk("dataAddr", memAddress, e.addr);
          chk("dataWe", 32'(memWriteEnable), 32'(e.wr));
          if (e.wr) chk("dataWdata", memWriteData, e.data);
          else      chk("dataRdata", dataReadData, e.data);
        end
      end
      if (fetchValid) begin
        if (expF.size() == 0) chk("fetchSpurious", 32'd1, 32'd0);
        else begin
          e = expF.pop_front();
          chk("fetchAddr", memAddress, e.addr);
          chk("fetchInstr", fetchInstruction, e.data);
        end
      end
    end
  end

  task automatic doData(bit rd, bit wr, logic [31:0] addr, logic [31:0] wd, int expEn, int dropAfter);
    exp_t e;
    int   n = 0;
    int   en = 0;
    bit   done = 1'b0;
    e.wr   = wr;
    e.addr = addr;
    e.data = wr ? wd : sbRead(addr);
    if (wr) sbMem[addr] = wd;
    expD.push_back(e);
    dataRead = rd; dataWrite = wr; dataAddress = addr; dataWriteData = wd;
    while (!done) begin
      @(negedge clk);
      #3;
      n++;
      if (memEnable) en++;
      if (dataValid) done = 1'b1;
      else if (n > 60) begin
        chk("dataTimeout", 32'd1, 32'd0);
        done = 1'b1;
      end else if (n == dropAfter) begin
        @(posedge clk);
        #1;
        dataRead = 1'b0; dataWrite = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    dataRead = 1'b0; dataWrite = 1'b0;
    if (expEn >= 0) chk("dataEnCycles", 32'(en), 32'(expEn));
  endtask

  task automatic doFetch(logic [31:0] addr, int expEn);
    exp_t e;
    int   n = 0;
    int   en = 0;
    bit   done = 1'b0;
    e.wr   = 1'b0;
    e.addr = addr;
    e.data = initWord(addr);
    expF.push_back(e);
    fetchReq = 1'b1; fetchAddress = addr;
    while (!done) begin
      @(negedge clk);
      #3;
      n++;
      if (memEnable) en++;
      if (fetchValid) done = 1'b1;
      else if (n > 60) begin
        chk("fetchTimeout", 32'd1, 32'd0);
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    fetchReq = 1'b0;
    if (expEn >= 0) chk("fetchEnCycles", 32'(en), 32'(expEn));
  endtask

  task automatic checkLog(string s);
    chk("grantCount", 32'(gLog.size()), 32'(s.len()));
    for (int i = 0; i < s.len(); i++)
      if (i < gLog.size()) chk("grantOrder", 32'(gLog[i]), 32'(s[i]));
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rstMemEnable", 32'(memEnable), 32'd0);
    chk("rstMemWe", 32'(memWriteEnable), 32'd0);
    chk("rstMemAddr", memAddress, 32'd0);
    chk("rstMemWdata", memWriteData, 32'd0);
    chk("rstDataValid", 32'(dataValid), 32'd0);
    repeat (2) @(negedge clk);
    #4 rst = 1'b1;
    @(posedge clk);
    #1;

    // Single load, latency 2
    lat = 2;
    doData(1'b1, 1'b0, 32'h40, 32'h0, 3, -1);

    // Stores and reads with memReady tied high (also ready in IDLE)
    lat = 0;
    tieReady = 1'b1;
    doData(1'b0, 1'b1, 32'h2100, 32'h12345678, 1, -1);
    doData(1'b1, 1'b1, 32'h2104, 32'hCAFEF00D, 1, -1);
    doData(1'b1, 1'b0, 32'h2100, 32'h0, 1, -1);
    doData(1'b1, 1'b0, 32'h2104, 32'h0, 1, -1);

    // Starvation limiter with both requesters held
    gLog.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) doData(1'b1, 1'b0, 32'h2400 + 32'(4 * i), 32'h0, -1, -1);
      end
      begin
        for (int j = 0; j < 2; j++) doFetch(32'h1000 + 32'(4 * j), -1);
      end
    join
    checkLog("DDDDFDDDDF");

    // Data request arriving during a latency-3 fetch waits for it
    tieReady = 1'b0;
    lat = 3;
    gLog.delete();
    fork
      doFetch(32'h1100, 4);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        doData(1'b1, 1'b0, 32'h2500, 32'h0, 7, -1);
      end
    join
    checkLog("FD");

    // Asynchronous reset in the middle of a data access
    lat = 5;
    gLog.delete();
    fork
      doData(1'b1, 1'b0, 32'h2600, 32'h0, -1, -1);
      begin
        repeat (3) @(negedge clk);
        #4 rst = 1'b0;
        #1;
        chk("midRstMemEnable", 32'(memEnable), 32'd0);
        chk("midRstDataValid", 32'(dataValid), 32'd0);
        chk("midRstMemAddr", memAddress, 32'd0);
        @(negedge clk);
        #4 rst = 1'b1;
      end
    join
    checkLog("DD");

    // Request dropped mid-access still completes
    lat = 2;
    doData(1'b1, 1'b0, 32'h2700, 32'h0, 3, 2);

    repeat (3) @(posedge clk);
    chk("dataQueueEmpty", 32'(expD.size()), 32'd0);
    chk("fetchQueueEmpty", 32'(expF.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish before 400000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
